// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants and the fetch queue entry type.
// FETCH_PREDECODE_EN adds is_branch/is_jal bits to each fetch entry.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
`ifdef FETCH_PREDECODE_EN
      logic            is_branch;
      logic            is_jal;
`endif
   } fetch_entry_t;

   function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
      fetch_entry_t e;
      e.instr = instr;
      e.pc = pc;
`ifdef FETCH_PREDECODE_EN
      e.is_branch = instr[6:0] == OPC_BRANCH;
      e.is_jal = instr[6:0] == OPC_JAL;
`endif
      return e;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO of fetch entries; clear beats push and pop.
// Entry type follows FETCH_PREDECODE_EN through riscv_pkg::fetch_entry_t.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t,
   parameter T    INIT  = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  T                         i_data,
   input  logic                     i_pop,
   output T                         o_head,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   T               r_mem [DEPTH];
   logic [AW-1:0]  r_wr;
   logic [AW-1:0]  r_rd;
   logic [AW:0]    r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT;
      end else if (i_clear) begin
         r_wr <= '0;
         r_rd <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr <= r_wr + 1'b1;
         end
         if (i_pop) r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end

   assign o_head = r_mem[r_rd];
   assign o_count = r_cnt;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC fetch into a one-cycle imem, buffered for decode, flushed by redirect.
// FETCH_PREDECODE_EN adds instr_is_branch/instr_is_jal outputs.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4,
   output logic        instr_valid,
`ifdef FETCH_PREDECODE_EN
   output logic        instr_is_branch,
   output logic        instr_is_jal,
`endif
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 2;
   localparam fetch_entry_t INIT_E = make_entry(NOP_INSTR, RESET_PC);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_inflight_pc;
   logic          r_inflight;
   logic          r_drop;
   logic [AW:0]   w_count;
   logic [CW-1:0] w_occ;
   logic          w_pop;
   logic          w_push;
   logic          w_unused;
   fetch_entry_t  w_head;

   assign instr_valid = w_count != '0;
   assign w_pop = instr_valid & instr_ready & ~redirect;
   assign w_push = r_inflight & imem_rvalid & ~r_drop & ~redirect;
   // Occupancy counts the in-flight word so a response always has a slot.
   assign w_occ = CW'(w_count) + CW'(r_inflight) - CW'(w_pop);
   assign imem_req = rst_n & ~redirect & (w_occ < CW'(DEPTH));
   assign imem_addr = r_fetch_pc;
   assign w_unused = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_inflight_pc <= RESET_PC;
         r_inflight <= 1'b0;
         r_drop <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_drop <= r_inflight;
         r_inflight <= 1'b0;
      end else begin
         r_drop <= 1'b0;
         r_inflight <= imem_req;
         if (imem_req) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t),
      .INIT  (INIT_E)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (redirect),
      .i_push  (w_push),
      .i_data  (make_entry(imem_rdata, r_inflight_pc)),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign instr = w_head.instr;
   assign instr_pc = w_head.pc;
   assign instr_pc_plus4 = w_head.pc + 32'd4;
`ifdef FETCH_PREDECODE_EN
   assign instr_is_branch = w_head.is_branch;
   assign instr_is_jal = w_head.is_jal;
`endif
endmodule
